// File: rtl/sobel_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_seq_ctrl
//
// Sequencer for a windowed Sobel datapath. For every output pixel it runs
// ACC_TAPS calculate/add iterations, one Sobel step, and then offers the result
// downstream until it is accepted. Windows are visited in raster order
// (col fastest). When the last pixel is accepted, a single-cycle frame_done
// pulse follows.
//
// Optional feature:
//   SEQ_ABORT_EN  - when defined, abort=1 returns any busy state except DONE to
//                   IDLE and clears the counters. No frame_done is issued. In
//                   IDLE, abort takes priority over start. When undefined, the
//                   abort port is still present but is ignored.
//
// Parameters:
//   IMG_W     image width in pixels (>=2)
//   IMG_H     image height in pixels (>=2)
//   ACC_TAPS  calculate/add iterations per window (>=1)
//
// Ports:
//   clk         clock, rising edge
//   n_rst       asynchronous active-low reset
//   start       frame start request, sampled only in IDLE
//   abort       frame abort request (SEQ_ABORT_EN builds only)
//   out_ready   downstream accepts the current Sobel result
//   calc_en     high in CALC
//   add_en      high in ADD
//   sobel_en    high in SOBEL
//   out_valid   high in OUT
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse in DONE
//   col/row     current window column/row
//   tap         current accumulation tap index
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start, counters at zero
// CALC  | calculate step for the current tap
// ADD   | accumulate the current tap, advance tap or go to SOBEL
// SOBEL | Sobel magnitude step for the current window
// OUT   | result offered downstream, held until out_ready
// DONE  | frame complete, one-cycle frame_done pulse
// -----------------------------------------------------------------------------
module sobel_seq_ctrl #(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int ACC_TAPS = 9,
  localparam int CW = (IMG_W    > 1) ? $clog2(IMG_W)    : 1,
  localparam int RW = (IMG_H    > 1) ? $clog2(IMG_H)    : 1,
  localparam int TW = (ACC_TAPS > 1) ? $clog2(ACC_TAPS) : 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic          abort,
  input  logic          out_ready,
  output logic          calc_en,
  output logic          add_en,
  output logic          sobel_en,
  output logic          out_valid,
  output logic          busy,
  output logic          frame_done,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic [TW-1:0] tap
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADD,
    ST_SOBEL,
    ST_OUT,
    ST_DONE
  } state_t;

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [TW-1:0] TAP_MAX = TW'(ACC_TAPS - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;
  logic [TW-1:0] tap_nxt;

`ifndef SEQ_ABORT_EN
  logic unused_abort;
  assign unused_abort = abort;
`endif

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    tap_nxt   = tap;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_CALC;
          col_nxt   = '0;
          row_nxt   = '0;
          tap_nxt   = '0;
        end
      end

      ST_CALC: state_nxt = ST_ADD;

      ST_ADD: begin
        if (tap == TAP_MAX) begin
          state_nxt = ST_SOBEL;
          tap_nxt   = '0;
        end else begin
          state_nxt = ST_CALC;
          tap_nxt   = tap + TW'(1);
        end
      end

      ST_SOBEL: state_nxt = ST_OUT;

      ST_OUT: begin
        if (out_ready) begin
          if (col == COL_MAX && row == ROW_MAX) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_CALC;
            // Explicit wrap so non-power-of-2 widths never reach an
            // out-of-range column.
            if (col == COL_MAX) begin
              col_nxt = '0;
              row_nxt = row + RW'(1);
            end else begin
              col_nxt = col + CW'(1);
            end
          end
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
        col_nxt   = '0;
        row_nxt   = '0;
        tap_nxt   = '0;
      end

      default: begin
        state_nxt = ST_IDLE;
        col_nxt   = '0;
        row_nxt   = '0;
        tap_nxt   = '0;
      end
    endcase

`ifdef SEQ_ABORT_EN
    // DONE is allowed to finish so that a completed frame always reports.
    if (abort && state != ST_DONE) begin
      state_nxt = ST_IDLE;
      col_nxt   = '0;
      row_nxt   = '0;
      tap_nxt   = '0;
    end
`endif
  end

  // Output flags are registered from the next-state value, so each flag is
  // exactly the decode of the state register it sits beside.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      col        <= '0;
      row        <= '0;
      tap        <= '0;
      calc_en    <= 1'b0;
      add_en     <= 1'b0;
      sobel_en   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      col        <= col_nxt;
      row        <= row_nxt;
      tap        <= tap_nxt;
      calc_en    <= (state_nxt == ST_CALC);
      add_en     <= (state_nxt == ST_ADD);
      sobel_en   <= (state_nxt == ST_SOBEL);
      out_valid  <= (state_nxt == ST_OUT);
      busy       <= (state_nxt != ST_IDLE);
      frame_done <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_sobel_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sobel_seq_ctrl
//
// Self-checking bench for sobel_seq_ctrl. Instance dut_a uses IMG_W=4,
// IMG_H=2, ACC_TAPS=2. Instance dut_b uses IMG_W=3, IMG_H=3, ACC_TAPS=3.
// Expected window coordinates are queued when a frame is started and are
// popped as each result is accepted. Abort expectations follow SEQ_ABORT_EN.
// -----------------------------------------------------------------------------
module tb_sobel_seq_ctrl;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  logic start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic a_calc_en, a_add_en, a_sobel_en, a_out_valid, a_busy, a_frame_done;
  logic [1:0] a_col;
  logic [0:0] a_row;
  logic [0:0] a_tap;

  logic b_start = 1'b0, b_abort = 1'b0, b_out_ready = 1'b1;
  logic b_calc_en, b_add_en, b_sobel_en, b_out_valid, b_busy, b_frame_done;
  logic [1:0] b_col;
  logic [1:0] b_row;
  logic [1:0] b_tap;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  sobel_seq_ctrl #(.IMG_W(4), .IMG_H(2), .ACC_TAPS(2)) dut_a (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .out_ready(out_ready), .calc_en(a_calc_en), .add_en(a_add_en),
    .sobel_en(a_sobel_en), .out_valid(a_out_valid), .busy(a_busy),
    .frame_done(a_frame_done), .col(a_col), .row(a_row), .tap(a_tap)
  );

  sobel_seq_ctrl #(.IMG_W(3), .IMG_H(3), .ACC_TAPS(3)) dut_b (
    .clk(clk), .n_rst(n_rst), .start(b_start), .abort(b_abort),
    .out_ready(b_out_ready), .calc_en(b_calc_en), .add_en(b_add_en),
    .sobel_en(b_sobel_en), .out_valid(b_out_valid), .busy(b_busy),
    .frame_done(b_frame_done), .col(b_col), .row(b_row), .tap(b_tap)
  );

  task automatic push_frame_a();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back(r * 16 + c);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    start = 1'b1;
    b_start = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({a_calc_en, a_add_en, a_sobel_en, a_out_valid, a_busy, a_frame_done,
         a_col, a_row, a_tap} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_a: outputs=%b required all 0",
               {a_calc_en, a_add_en, a_sobel_en, a_out_valid, a_busy,
                a_frame_done, a_col, a_row, a_tap});
    end
    vectors++;
    if ({b_calc_en, b_add_en, b_sobel_en, b_out_valid, b_busy, b_frame_done,
         b_col, b_row, b_tap} !== 12'b0) begin
      miscompares++;
      $display("FAIL reset_b: outputs=%b required all 0",
               {b_calc_en, b_add_en, b_sobel_en, b_out_valid, b_busy,
                b_frame_done, b_col, b_row, b_tap});
    end
    start = 1'b0;
    b_start = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b required 0", a_busy);
    end
  endtask

  task automatic test_frame_timing();
    int cyc, done_cnt, done_idx, sob_cnt, last_sob, e;
    push_frame_a();
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (a_calc_en !== 1'b1 || a_col !== 2'd0 || a_row !== 1'd0 || a_tap !== 1'd0) begin
      miscompares++;
      $display("FAIL calc_latency: calc_en=%b col=%0d row=%0d tap=%0d required 1,0,0,0",
               a_calc_en, a_col, a_row, a_tap);
    end
    cyc = 0; done_cnt = 0; done_idx = -1; sob_cnt = 0; last_sob = -1;
    while (cyc < 200) begin
      if (a_sobel_en) begin
        if (last_sob >= 0) begin
          vectors++;
          if (cyc - last_sob != 6) begin
            miscompares++;
            $display("FAIL sobel_spacing: gap=%0d required 6", cyc - last_sob);
          end
        end
        last_sob = cyc;
        sob_cnt++;
      end
      if (a_out_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL order: extra result at (%0d,%0d) required none", a_col, a_row);
        end else begin
          e = exp_q.pop_front();
          if (a_col !== 2'(e % 16) || a_row !== 1'(e / 16)) begin
            miscompares++;
            $display("FAIL order: got (%0d,%0d) required (%0d,%0d)",
                     a_col, a_row, e % 16, e / 16);
          end
        end
      end
      if (a_frame_done) begin
        done_cnt++;
        done_idx = cyc;
      end
      if (!a_busy) break;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc >= 200) begin
      miscompares++;
      $display("FAIL frame_timeout: busy=%b required 0 within 200 cycles", a_busy);
    end
    vectors++;
    if (sob_cnt != 8) begin
      miscompares++;
      $display("FAIL sobel_count: got %0d required 8", sob_cnt);
    end
    vectors++;
    if (done_cnt != 1) begin
      miscompares++;
      $display("FAIL done_count: got %0d required 1", done_cnt);
    end
    vectors++;
    if (done_idx + 1 != 49) begin
      miscompares++;
      $display("FAIL frame_cost: got %0d cycles required 49", done_idx + 1);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL order_missing: %0d results outstanding required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_backpressure();
    int cyc, held, done_cnt, e;
    bit stalled;
    push_frame_a();
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; held = 0; done_cnt = 0; stalled = 1'b0;
    while (cyc < 300) begin
      if (stalled) begin
        vectors++;
        if (a_out_valid !== 1'b1 || a_col !== 2'd2 || a_row !== 1'd0) begin
          miscompares++;
          $display("FAIL hold: out_valid=%b col=%0d row=%0d required 1,2,0",
                   a_out_valid, a_col, a_row);
        end
      end
      if (a_frame_done) done_cnt++;
      if (!a_busy) break;
      if (a_out_valid) begin
        if (a_col == 2'd2 && a_row == 1'd0 && held < 5) begin
          out_ready = 1'b0;
          held++;
          stalled = 1'b1;
        end else begin
          out_ready = 1'b1;
          stalled = 1'b0;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL bp_order: extra result at (%0d,%0d) required none", a_col, a_row);
          end else begin
            e = exp_q.pop_front();
            if (a_col !== 2'(e % 16) || a_row !== 1'(e / 16)) begin
              miscompares++;
              $display("FAIL bp_order: got (%0d,%0d) required (%0d,%0d)",
                       a_col, a_row, e % 16, e / 16);
            end
          end
        end
      end else begin
        // out_ready is irrelevant outside OUT, so wiggle it there.
        out_ready = 1'($urandom_range(0, 1));
        stalled = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    vectors++;
    if (cyc >= 300 || done_cnt != 1 || held != 5 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_frame: cycles=%0d done=%0d held=%0d left=%0d required <300,1,5,0",
               cyc, done_cnt, held, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_mid_reset();
    int cyc, done_cnt, e;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; done_cnt = 0;
    while (cyc < 200 && !(a_add_en && a_col == 2'd1 && a_row == 1'd1)) begin
      if (a_frame_done) done_cnt++;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc >= 200) begin
      miscompares++;
      $display("FAIL mid_reset_reach: ADD of (1,1) not seen, required within 200 cycles");
    end
    #2 n_rst = 1'b0;
    #1;
    vectors++;
    if ({a_calc_en, a_add_en, a_sobel_en, a_out_valid, a_busy, a_frame_done,
         a_col, a_row, a_tap} !== 10'b0) begin
      miscompares++;
      $display("FAIL async_reset: outputs=%b required all 0",
               {a_calc_en, a_add_en, a_sobel_en, a_out_valid, a_busy,
                a_frame_done, a_col, a_row, a_tap});
    end
    @(negedge clk);
    if (a_frame_done) done_cnt++;
    vectors++;
    if (done_cnt != 0) begin
      miscompares++;
      $display("FAIL aborted_done: frame_done seen %0d times required 0", done_cnt);
    end
    n_rst = 1'b1;
    start = 1'b1;
    push_frame_a();
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (a_calc_en !== 1'b1 || a_col !== 2'd0 || a_row !== 1'd0) begin
      miscompares++;
      $display("FAIL restart: calc_en=%b col=%0d row=%0d required 1,0,0",
               a_calc_en, a_col, a_row);
    end
    cyc = 0; done_cnt = 0;
    while (cyc < 200 && a_busy) begin
      if (a_frame_done) done_cnt++;
      if (a_out_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL restart_order: extra result at (%0d,%0d) required none", a_col, a_row);
        end else begin
          e = exp_q.pop_front();
          if (a_col !== 2'(e % 16) || a_row !== 1'(e / 16)) begin
            miscompares++;
            $display("FAIL restart_order: got (%0d,%0d) required (%0d,%0d)",
                     a_col, a_row, e % 16, e / 16);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc >= 200 || done_cnt != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL restart_frame: cycles=%0d done=%0d left=%0d required <200,1,0",
               cyc, done_cnt, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_abort();
    int cyc, done_cnt, outs;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; done_cnt = 0; outs = 0;
    while (cyc < 200 && !(a_calc_en && a_col == 2'd3 && a_row == 1'd0)) begin
      if (a_out_valid) outs++;
      @(negedge clk);
      cyc++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`ifdef SEQ_ABORT_EN
    vectors++;
    if (a_busy !== 1'b0 || a_col !== 2'd0 || a_row !== 1'd0 || a_tap !== 1'd0) begin
      miscompares++;
      $display("FAIL abort_idle: busy=%b col=%0d row=%0d tap=%0d required 0,0,0,0",
               a_busy, a_col, a_row, a_tap);
    end
    repeat (5) begin
      if (a_frame_done) done_cnt++;
      @(negedge clk);
    end
    vectors++;
    if (done_cnt != 0 || a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_nodone: done=%0d busy=%b required 0,0", done_cnt, a_busy);
    end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    vectors++;
    if (a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_priority: busy=%b required 0", a_busy);
    end
`else
    cyc = 0;
    while (cyc < 200 && a_busy) begin
      if (a_out_valid) outs++;
      if (a_frame_done) done_cnt++;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (done_cnt != 1 || outs != 8) begin
      miscompares++;
      $display("FAIL abort_ignored: done=%0d outs=%0d required 1,8", done_cnt, outs);
    end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    vectors++;
    if (a_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_start: busy=%b required 1", a_busy);
    end
    cyc = 0;
    while (cyc < 200 && a_busy) begin
      @(negedge clk);
      cyc++;
    end
`endif
  endtask

  task automatic test_npot_busy_start();
    int cyc, done_cnt, done_idx, first, e;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        exp_q.push_back(r * 16 + c);
    b_out_ready = 1'b1;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc = 0; done_cnt = 0; done_idx = -1; first = -1;
    while (cyc < 300 && b_busy) begin
      if (b_calc_en && first < 0) first = cyc;
      vectors++;
      if (b_col > 2'd2 || b_row > 2'd2 || b_tap > 2'd2) begin
        miscompares++;
        $display("FAIL npot_range: col=%0d row=%0d tap=%0d required each <=2",
                 b_col, b_row, b_tap);
      end
      if (b_out_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL npot_order: extra result at (%0d,%0d) required none", b_col, b_row);
        end else begin
          e = exp_q.pop_front();
          if (b_col !== 2'(e % 16) || b_row !== 2'(e / 16)) begin
            miscompares++;
            $display("FAIL npot_order: got (%0d,%0d) required (%0d,%0d)",
                     b_col, b_row, e % 16, e / 16);
          end
        end
      end
      if (b_frame_done) begin
        done_cnt++;
        done_idx = cyc;
      end
      b_start = (cyc % 7 == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    b_start = 1'b0;
    vectors++;
    if (cyc >= 300 || done_cnt != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL npot_frame: cycles=%0d done=%0d left=%0d required <300,1,0",
               cyc, done_cnt, exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (done_idx - first + 1 != 73) begin
      miscompares++;
      $display("FAIL npot_cost: got %0d cycles required 73", done_idx - first + 1);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (b_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL npot_no_queue: busy=%b required 0", b_busy);
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_backpressure();
    test_mid_reset();
    test_abort();
    test_npot_busy_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sobel_seq_ctrl.md
SOBEL_SEQ_CTRL -- requirements
Module: sobel_seq_ctrl

Interface
REQ-001 Parameter IMG_W, default 8, image width in pixels (>=2).
REQ-002 Parameter IMG_H, default 8, image height in pixels (>=2).
REQ-003 Parameter ACC_TAPS, default 9, calculate/add iterations per window (>=1).
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 n_rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  frame start request, sampled only in IDLE.
REQ-007 abort  input  1  frame abort request, used only with SEQ_ABORT_EN.
REQ-008 out_ready  input  1  downstream accepts current Sobel result.
REQ-009 calc_en  output  1  high in CALC.
REQ-010 add_en  output  1  high in ADD.
REQ-011 sobel_en  output  1  high in SOBEL.
REQ-012 out_valid  output  1  high in OUT.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 frame_done  output  1  one-cycle pulse, high in DONE.
REQ-015 col  output  CW=max(1,$clog2(IMG_W))  current window column.
REQ-016 row  output  RW=max(1,$clog2(IMG_H))  current window row.
REQ-017 tap  output  TW=max(1,$clog2(ACC_TAPS))  current accumulation tap index.

Function
REQ-018 FSM states: IDLE, CALC, ADD, SOBEL, OUT, DONE. All outputs are Moore-decoded from registered state and counters.
REQ-019 IDLE: start=1 -> CALC with col=0, row=0, tap=0. Otherwise stay in IDLE.
REQ-020 CALC -> ADD unconditionally after 1 cycle.
REQ-021 ADD: if tap==ACC_TAPS-1 -> SOBEL with tap cleared to 0. Otherwise tap+1 -> CALC.
REQ-022 SOBEL -> OUT unconditionally after 1 cycle.
REQ-023 OUT: hold while out_ready=0. col, row and tap stay stable while held.
REQ-024 OUT with out_ready=1 at the last pixel (col==IMG_W-1 and row==IMG_H-1) -> DONE.
REQ-025 OUT with out_ready=1 at any other pixel -> CALC. col+1, or col=0 and row+1 when col==IMG_W-1.
REQ-026 DONE -> IDLE after 1 cycle. col, row and tap clear to 0.
REQ-027 Window cost is 2*ACC_TAPS+2 cycles when out_ready=1. Frame cost is IMG_W*IMG_H*(2*ACC_TAPS+2)+1 cycles from the first CALC to the end of DONE.
REQ-028 start is ignored whenever busy=1. No queueing occurs.
REQ-029 out_ready is ignored in all states other than OUT.
REQ-030 Counters never exceed IMG_W-1, IMG_H-1 or ACC_TAPS-1. Non-power-of-2 sizes wrap explicitly and do not rely on natural overflow.
REQ-031 No latch inference: every combinational next-state and next-counter value is defaulted.

Reset
REQ-032 n_rst=0 forces IDLE and col=row=tap=0 immediately, regardless of clk.
REQ-033 While n_rst=0, all outputs are 0. This holds for calc_en, add_en, sobel_en, out_valid, busy, frame_done, col, row and tap.
REQ-034 Reset asserted mid-frame discards progress. No frame_done is produced, and the next frame starts at (0,0).
REQ-035 The first start can be accepted on the first rising edge after n_rst deasserts.

Configuration
REQ-036 Macro SEQ_ABORT_EN enables abort handling. The abort port is present in both builds.
REQ-037 With SEQ_ABORT_EN: abort=1 in any busy state except DONE -> IDLE on the next edge, with counters cleared and no frame_done pulse. In IDLE, abort has priority over start.
REQ-038 Without SEQ_ABORT_EN, abort has no effect on any state or output.

Verification (IMG_W=4, IMG_H=2, ACC_TAPS=2 unless noted)
REQ-039 Frame timing: start pulse, out_ready=1 -> first calc_en on the next cycle. The frame shows 8 sobel_en pulses 6 cycles apart, and frame_done pulses exactly once, 49 cycles after the first calc_en.
REQ-040 Traversal order: full frame -> (col,row) at each out_valid runs (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1).
REQ-041 Backpressure: hold out_ready=0 for 5 cycles at (2,0) -> out_valid stays high for 5 cycles with col=2 and row=0 stable. The sequence resumes at (3,0).
REQ-042 Mid-frame reset: assert n_rst=0 during ADD of window (1,1) -> all outputs go to 0 asynchronously. A new start restarts at (0,0), and no frame_done is seen for the aborted frame.
REQ-043 Abort: with SEQ_ABORT_EN, abort in CALC of window (3,0) -> IDLE next cycle, no frame_done. Without the macro, the same stimulus completes the frame normally.
REQ-044 Non-power-of-2 and start while busy: IMG_W=3, IMG_H=3, ACC_TAPS=3 -> col wraps 2->0 and 9 windows complete. Start pulses issued while busy are ignored.
